// File: rtl/fb_video_pkg.sv
// Shared definitions for fb_video: timing defaults, palette entry type and the
// 128-entry NTSC/PAL colour ROMs indexed by a 7-bit colour index.
package fb_video_pkg;

  localparam int DEF_HA    = 640;
  localparam int DEF_HFP   = 16;
  localparam int DEF_HS    = 96;
  localparam int DEF_HBP   = 48;
  localparam int DEF_VA    = 480;
  localparam int DEF_VFP   = 11;
  localparam int DEF_VS    = 2;
  localparam int DEF_VBP   = 31;
  localparam int DEF_SRC_W = 160;
  localparam int DEF_SRC_H = 240;
  localparam int DEF_SX    = 4;
  localparam int DEF_SY    = 2;
  localparam int DEF_AW    = 16;

  typedef logic [23:0] pal_entry_t;

  // Eight luminance steps per hue, sixteen hues.
  localparam pal_entry_t NTSC_PALETTE [128] = '{
    24'h000000, 24'h404040, 24'h6c6c6c, 24'h909090, 24'hb0b0b0, 24'hc8c8c8, 24'hdcdcdc, 24'hececec,
    24'h444400, 24'h646410, 24'h848424, 24'ha0a034, 24'hb8b840, 24'hd0d050, 24'he8e85c, 24'hfcfc68,
    24'h702800, 24'h844414, 24'h985c28, 24'hac783c, 24'hbc8c4c, 24'hcca05c, 24'hdcb468, 24'hecc878,
    24'h841800, 24'h983418, 24'hac5030, 24'hc06848, 24'hd0805c, 24'he09470, 24'heca880, 24'hfcbc94,
    24'h880000, 24'h9c2020, 24'hb03c3c, 24'hc05858, 24'hd07070, 24'he08888, 24'heca0a0, 24'hfcb4b4,
    24'h78005c, 24'h8c2074, 24'ha03c88, 24'hb0589c, 24'hc070b0, 24'hd084c0, 24'hdc9cd0, 24'hecb0e0,
    24'h480078, 24'h602090, 24'h783ca4, 24'h8c58b8, 24'ha070cc, 24'hb484dc, 24'hc49cec, 24'hd4b0fc,
    24'h140084, 24'h302098, 24'h4c3cac, 24'h6858c0, 24'h7c70d0, 24'h9488e0, 24'ha8a0ec, 24'hbcb4fc,
    24'h000088, 24'h1c209c, 24'h3840b0, 24'h505cc0, 24'h6874d0, 24'h7c8ce0, 24'h90a4ec, 24'ha4b8fc,
    24'h00187c, 24'h1c3890, 24'h3854a8, 24'h5070bc, 24'h6888cc, 24'h7c9cdc, 24'h90b4ec, 24'ha4c8fc,
    24'h002c5c, 24'h1c4c78, 24'h386890, 24'h5084ac, 24'h689cc0, 24'h7cb4d4, 24'h90cce8, 24'ha4e0fc,
    24'h003c2c, 24'h1c5c48, 24'h387c64, 24'h509c80, 24'h68b494, 24'h7cd0ac, 24'h90e4c0, 24'ha4fcd4,
    24'h003c00, 24'h205c20, 24'h407c40, 24'h5c9c5c, 24'h74b474, 24'h8cd08c, 24'ha4e4a4, 24'hb8fcb8,
    24'h143800, 24'h345c1c, 24'h507c38, 24'h6c9850, 24'h84b468, 24'h9ccc7c, 24'hb4e490, 24'hc8fca4,
    24'h2c3000, 24'h4c501c, 24'h687034, 24'h848c4c, 24'h9ca864, 24'hb4c078, 24'hccd488, 24'he0ec9c,
    24'h442800, 24'h644818, 24'h846830, 24'ha08444, 24'hb89c58, 24'hd0b46c, 24'he8cc7c, 24'hfce08c
  };

  localparam pal_entry_t PAL_PALETTE [128] = '{
    24'h000000, 24'h282828, 24'h505050, 24'h747474, 24'h949494, 24'hb4b4b4, 24'hd0d0d0, 24'hececec,
    24'h000000, 24'h282828, 24'h505050, 24'h747474, 24'h949494, 24'hb4b4b4, 24'hd0d0d0, 24'hececec,
    24'h805800, 24'h947020, 24'ha8843c, 24'hbc9c58, 24'hccac70, 24'hdcc084, 24'hecd09c, 24'hfce0b0,
    24'h445c00, 24'h5c7820, 24'h74903c, 24'h8cac58, 24'ha0c070, 24'hb0d484, 24'hc4e89c, 24'hd4fcb0,
    24'h703400, 24'h885020, 24'ha0683c, 24'hb48458, 24'hc89870, 24'hdcac84, 24'hecc09c, 24'hfcd4b0,
    24'h006414, 24'h208034, 24'h3c9850, 24'h58b06c, 24'h70c484, 24'h84d89c, 24'h9ce8b4, 24'hb0fcc8,
    24'h700014, 24'h882034, 24'ha03c50, 24'hb4586c, 24'hc87084, 24'hdc849c, 24'hec9cb4, 24'hfcb0c8,
    24'h005c5c, 24'h207474, 24'h3c8c8c, 24'h58a4a4, 24'h70b8b8, 24'h84c8c8, 24'h9cdcdc, 24'hb0ecec,
    24'h70005c, 24'h842074, 24'h943c88, 24'ha8589c, 24'hb470b0, 24'hc484c0, 24'hd09cd0, 24'he0b0e0,
    24'h003c70, 24'h1c5888, 24'h3874a0, 24'h508cb4, 24'h68a4c8, 24'h7cb8dc, 24'h90ccec, 24'ha4e0fc,
    24'h580070, 24'h6c2088, 24'h803ca0, 24'h9458b4, 24'ha470c8, 24'hb484dc, 24'hc49cec, 24'hd4b0fc,
    24'h002070, 24'h1c3c88, 24'h3858a0, 24'h5074b4, 24'h6888c8, 24'h7ca0dc, 24'h90b4ec, 24'ha4c8fc,
    24'h3c0080, 24'h542094, 24'h6c3ca8, 24'h8058bc, 24'h9470cc, 24'ha884dc, 24'hb89cec, 24'hc8b0fc,
    24'h000088, 24'h20209c, 24'h3c3cb0, 24'h5858c0, 24'h7070d0, 24'h8888e0, 24'ha0a0ec, 24'hb4b4fc,
    24'h000000, 24'h282828, 24'h505050, 24'h747474, 24'h949494, 24'hb4b4b4, 24'hd0d0d0, 24'hececec,
    24'h000000, 24'h282828, 24'h505050, 24'h747474, 24'h949494, 24'hb4b4b4, 24'hd0d0d0, 24'hececec
  };

  function automatic pal_entry_t pal_lookup(input logic pal_sel, input logic [6:0] idx);
    pal_entry_t entry;
    if (pal_sel) begin
      entry = PAL_PALETTE[idx];
    end else begin
      entry = NTSC_PALETTE[idx];
    end
    return entry;
  endfunction

  // Halve each 8-bit channel with a logical shift.
  function automatic pal_entry_t dim_entry(input pal_entry_t c);
    return {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
  endfunction

endpackage

// File: rtl/fb_video_timing.sv
// Raster counters for fb_video: hc/vc, picture-window decode at S0 and the
// registered (S1) sync, display-enable, vblank, frame-start and window flags.
module fb_video_timing #(
  parameter int   HA     = 640,
  parameter int   HFP    = 16,
  parameter int   HS     = 96,
  parameter int   HBP    = 48,
  parameter int   VA     = 480,
  parameter int   VFP    = 11,
  parameter int   VS     = 2,
  parameter int   VBP    = 31,
  parameter int   HOFF   = 0,
  parameter int   VOFF   = 0,
  parameter int   PW     = 640,
  parameter int   PH     = 480,
  parameter int   HW     = 10,
  parameter int   VW     = 10,
  parameter logic HS_POL = 1'b0,
  parameter logic VS_POL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  output logic pic_now,
  output logic pic_last,
  output logic frame_wrap,
  output logic origin,
  output logic de,
  output logic hs,
  output logic vs,
  output logic vblank,
  output logic frame_start,
  output logic pic
);

  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;

  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic          h_end;
  logic          v_end;
  logic          de_now;
  logic          hs_now;
  logic          vs_now;
  logic          vb_now;

  // Window tests use offset-and-wrap compares so a zero offset needs no lower bound.
  always_comb begin
    h_end      = (hc == HW'(HT - 1));
    v_end      = (vc == VW'(VT - 1));
    frame_wrap = h_end && v_end;
    origin     = (hc == '0) && (vc == '0);
    de_now     = (hc < HW'(HA)) && (vc < VW'(VA));
    hs_now     = (hc >= HW'(HA + HFP)) && (hc < HW'(HA + HFP + HS));
    vs_now     = (vc >= VW'(VA + VFP)) && (vc < VW'(VA + VFP + VS));
    vb_now     = (vc >= VW'(VA));
    pic_now    = (HW'(hc - HW'(HOFF)) < HW'(PW)) && (VW'(vc - VW'(VOFF)) < VW'(PH));
    pic_last   = pic_now && (hc == HW'(HOFF + PW - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hc <= '0;
      vc <= '0;
    end else if (h_end) begin
      hc <= '0;
      vc <= v_end ? '0 : vc + 1'b1;
    end else begin
      hc <= hc + 1'b1;
      vc <= vc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      de          <= 1'b0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      vblank      <= 1'b0;
      frame_start <= 1'b0;
      pic         <= 1'b0;
    end else begin
      de          <= de_now;
      hs          <= hs_now ? HS_POL : ~HS_POL;
      vs          <= vs_now ? VS_POL : ~VS_POL;
      vblank      <= vb_now;
      frame_start <= origin;
      pic         <= pic_now;
    end
  end

endmodule

// File: rtl/fb_video.sv
// Framebuffer-to-VGA generator: incremental address generation, palette lookup
// and 3-stage output alignment. Optional macro FB_VIDEO_SCANLINE_EN dims odd scaled rows.
module fb_video
  import fb_video_pkg::*;
#(
  parameter int   HA     = DEF_HA,
  parameter int   HFP    = DEF_HFP,
  parameter int   HS     = DEF_HS,
  parameter int   HBP    = DEF_HBP,
  parameter int   VA     = DEF_VA,
  parameter int   VFP    = DEF_VFP,
  parameter int   VS     = DEF_VS,
  parameter int   VBP    = DEF_VBP,
  parameter int   SRC_W  = DEF_SRC_W,
  parameter int   SRC_H  = DEF_SRC_H,
  parameter int   SX     = DEF_SX,
  parameter int   SY     = DEF_SY,
  parameter int   AW     = DEF_AW,
  parameter logic HS_POL = 1'b0,
  parameter logic VS_POL = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pal_mode,
  input  logic [6:0]    border_col,
  input  logic [6:0]    vga_data,
  output logic [AW-1:0] vga_addr,
  output logic [7:0]    vga_r,
  output logic [7:0]    vga_g,
  output logic [7:0]    vga_b,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          vga_de,
  output logic          vblank,
  output logic          frame_start
);

  localparam int HT   = HA + HFP + HS + HBP;
  localparam int VT   = VA + VFP + VS + VBP;
  localparam int PW   = SRC_W * SX;
  localparam int PH   = SRC_H * SY;
  localparam int HOFF = (HA - PW) / 2;
  localparam int VOFF = (VA - PH) / 2;
  localparam int HW   = $clog2(HT);
  localparam int VW   = $clog2(VT);
  localparam int CW   = (SX > 1) ? $clog2(SX) : 1;
  localparam int RW   = (SY > 1) ? $clog2(SY) : 1;

  if ((HA < PW) || (VA < PH)) begin : g_window_check
    $error("fb_video: scaled framebuffer does not fit inside the active area");
  end

  logic          pic_now, pic_last, frame_wrap, origin;
  logic          de1, hs1, vs1, vb1, fs1, pic1;
  logic          de2, hs2, vs2, vb2, fs2, pic2;
  logic          dim_now, dim1, dim2;
  logic [CW-1:0] col_sub;
  logic [RW-1:0] row_sub;
  logic [AW-1:0] src_col;
  logic [AW-1:0] row_base;
  logic          pal_sel;
  logic [6:0]    pix_idx;
  pal_entry_t    base_colour;
  pal_entry_t    shown_colour;

  fb_video_timing #(
    .HA(HA), .HFP(HFP), .HS(HS), .HBP(HBP),
    .VA(VA), .VFP(VFP), .VS(VS), .VBP(VBP),
    .HOFF(HOFF), .VOFF(VOFF), .PW(PW), .PH(PH),
    .HW(HW), .VW(VW), .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_timing (
    .clk(clk), .reset(reset),
    .pic_now(pic_now), .pic_last(pic_last), .frame_wrap(frame_wrap), .origin(origin),
    .de(de1), .hs(hs1), .vs(vs1), .vblank(vb1), .frame_start(fs1), .pic(pic1)
  );

  // Column/row sub-counters replace the divide; the address holds outside the picture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      col_sub  <= '0;
      src_col  <= '0;
      row_sub  <= '0;
      row_base <= '0;
      vga_addr <= '0;
    end else begin
      if (pic_now) begin
        vga_addr <= row_base + src_col;
        if (col_sub == CW'(SX - 1)) begin
          col_sub <= '0;
          src_col <= src_col + 1'b1;
        end else begin
          col_sub <= col_sub + 1'b1;
        end
      end else begin
        col_sub <= '0;
        src_col <= '0;
      end
      if (frame_wrap) begin
        row_sub  <= '0;
        row_base <= '0;
      end else if (pic_last) begin
        if (row_sub == RW'(SY - 1)) begin
          row_sub  <= '0;
          row_base <= row_base + AW'(SRC_W);
        end else begin
          row_sub <= row_sub + 1'b1;
        end
      end
    end
  end

  // Palette choice only changes at the top-left corner so a frame never mixes palettes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pal_sel <= 1'b0;
    end else if (origin) begin
      pal_sel <= pal_mode;
    end
  end

  always_comb begin
`ifdef FB_VIDEO_SCANLINE_EN
    dim_now = pic_now && (row_sub != '0);
`else
    dim_now = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dim1 <= 1'b0;
      dim2 <= 1'b0;
      de2  <= 1'b0;
      hs2  <= ~HS_POL;
      vs2  <= ~VS_POL;
      vb2  <= 1'b0;
      fs2  <= 1'b0;
      pic2 <= 1'b0;
    end else begin
      dim1 <= dim_now;
      dim2 <= dim1;
      de2  <= de1;
      hs2  <= hs1;
      vs2  <= vs1;
      vb2  <= vb1;
      fs2  <= fs1;
      pic2 <= pic1;
    end
  end

  // S2: RAM data has arrived; border_col is taken live here.
  always_comb begin
    pix_idx      = pic2 ? vga_data : border_col;
    base_colour  = pal_lookup(pal_sel, pix_idx);
    shown_colour = dim2 ? dim_entry(base_colour) : base_colour;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vga_r       <= 8'h00;
      vga_g       <= 8'h00;
      vga_b       <= 8'h00;
      vga_de      <= 1'b0;
      vga_hs      <= ~HS_POL;
      vga_vs      <= ~VS_POL;
      vblank      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vga_r       <= de2 ? shown_colour[23:16] : 8'h00;
      vga_g       <= de2 ? shown_colour[15:8]  : 8'h00;
      vga_b       <= de2 ? shown_colour[7:0]   : 8'h00;
      vga_de      <= de2;
      vga_hs      <= hs2;
      vga_vs      <= vs2;
      vblank      <= vb2;
      frame_start <= fs2;
    end
  end

endmodule
